ds1302_ctrl: RTL and testbench

- Transaction sequencer that sits directly upstream of the DS1302 single-byte I/O engine, driving its command/ack interface.
- On reset it runs an init sequence: clears write-protect, then clears the clock-halt bit.
- It then polls the seven calendar registers at a fixed rate and presents a coherent BCD time snapshot to the application.
- It also accepts a one-shot request to set the full date/time.

---
 rtl/ds1302_ctrl_if.sv | 27 ++
 rtl/ds1302_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_ds1302_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ds1302_ctrl_if.sv
// ds1302_ctrl_if: command/ack bus between the DS1302 transaction sequencer
// (master) and the single-byte DS1302 I/O engine (slave).
//   cmd_read / cmd_write        : registered commands, never high together
//   cmd_read_ack / cmd_write_ack: 1-cycle completion strobes from the engine
//   read_addr / write_addr      : DS1302 register addresses, stable while a command is high
//   write_data                  : byte to write, stable while cmd_write is high
//   read_data                   : byte returned, valid in the cmd_read_ack cycle
interface ds1302_ctrl_if;
  logic       cmd_read;
  logic       cmd_write;
  logic       cmd_read_ack;
  logic       cmd_write_ack;
  logic [7:0] read_addr;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic [7:0] read_data;

  modport master (
    output cmd_read, cmd_write, read_addr, write_addr, write_data,
    input  cmd_read_ack, cmd_write_ack, read_data
  );

  modport slave (
    input  cmd_read, cmd_write, read_addr, write_addr, write_data,
    output cmd_read_ack, cmd_write_ack, read_data
  );
endinterface

// File: rtl/ds1302_ctrl.sv
// ds1302_ctrl: transaction sequencer for the DS1302 RTC.
// After reset it clears write-protect and the clock-halt bit, then polls the
// seven calendar registers every POLL_DIV cycles and presents a coherent BCD
// snapshot. A one-shot set request writes all seven registers, followed by an
// immediate refresh poll.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   set_req, set_*    : set request and date/time values (captured on request)
//   set_ack           : 1-cycle pulse when all seven set writes are done
//   sec..year         : last polled snapshot, raw register bytes
//   time_valid        : 1-cycle pulse when the snapshot updates
//   init_done         : high once the init sequence has completed
//   busy              : a command is outstanding on the I/O engine bus
//   io                : command/ack bus to the DS1302 I/O engine
module ds1302_ctrl #(
  parameter int unsigned POLL_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_req,
  input  logic [7:0] set_sec,
  input  logic [7:0] set_min,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_date,
  input  logic [7:0] set_month,
  input  logic [7:0] set_day,
  input  logic [7:0] set_year,
  output logic       set_ack,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] date,
  output logic [7:0] month,
  output logic [7:0] day,
  output logic [7:0] year,
  output logic       time_valid,
  output logic       init_done,
  output logic       busy,
  ds1302_ctrl_if.master io
);

  localparam int unsigned CNT_W = $clog2(POLL_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);

  localparam logic [2:0] S_INIT_WP = 3'd0;
  localparam logic [2:0] S_INIT_RD = 3'd1;
  localparam logic [2:0] S_INIT_WR = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_POLL_RD = 3'd4;
  localparam logic [2:0] S_SET_WR  = 3'd5;

  logic [2:0]       state;
  logic [2:0]       idx;
  logic [CNT_W-1:0] poll_cnt;
  logic             set_pend;
  logic [7:0]       set_val [0:6];
  logic [7:0]       shadow  [0:5];
  logic [7:0]       init_sec;

  logic             cmd_read_r;
  logic             cmd_write_r;
  logic [7:0]       read_addr_r;
  logic [7:0]       write_addr_r;
  logic [7:0]       write_data_r;

  logic             rd_done;
  logic             wr_done;
  logic             issue_rd;
  logic             issue_wr;
  logic [7:0]       rd_addr_nxt;
  logic [7:0]       wr_addr_nxt;
  logic [7:0]       wr_data_nxt;

  assign io.cmd_read   = cmd_read_r;
  assign io.cmd_write  = cmd_write_r;
  assign io.read_addr  = read_addr_r;
  assign io.write_addr = write_addr_r;
  assign io.write_data = write_data_r;

  assign busy    = cmd_read_r | cmd_write_r;
  // Acks only count while the matching command is actually outstanding.
  assign rd_done = cmd_read_r  & io.cmd_read_ack;
  assign wr_done = cmd_write_r & io.cmd_write_ack;

  // Which command the current state wants, and its address/data.
  always_comb begin
    issue_rd    = 1'b0;
    issue_wr    = 1'b0;
    rd_addr_nxt = 8'h81 + {4'h0, idx, 1'b0};
    wr_addr_nxt = 8'h80 + {4'h0, idx, 1'b0};
    wr_data_nxt = set_val[idx];
    case (state)
      S_INIT_WP: begin
        issue_wr    = 1'b1;
        wr_addr_nxt = 8'h8E;
        wr_data_nxt = '0;
      end
      S_INIT_RD: begin
        issue_rd    = 1'b1;
        rd_addr_nxt = 8'h81;
      end
      S_INIT_WR: begin
        // Rewrite seconds with the clock-halt bit cleared.
        issue_wr    = 1'b1;
        wr_addr_nxt = 8'h80;
        wr_data_nxt = {1'b0, init_sec[6:0]};
      end
      S_POLL_RD: issue_rd = 1'b1;
      S_SET_WR: begin
        issue_wr = 1'b1;
        if (idx == 3'd0) wr_data_nxt = {1'b0, set_val[0][6:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_INIT_WP;
      idx          <= '0;
      poll_cnt     <= '0;
      set_pend     <= 1'b0;
      init_sec     <= '0;
      cmd_read_r   <= 1'b0;
      cmd_write_r  <= 1'b0;
      read_addr_r  <= 8'h81;
      write_addr_r <= 8'h8E;
      write_data_r <= '0;
      set_ack      <= 1'b0;
      time_valid   <= 1'b0;
      init_done    <= 1'b0;
      sec          <= '0;
      min          <= '0;
      hour         <= '0;
      date         <= '0;
      month        <= '0;
      day          <= '0;
      year         <= '0;
      for (int unsigned i = 0; i < 7; i++) set_val[i] <= '0;
      for (int unsigned i = 0; i < 6; i++) shadow[i] <= '0;
    end else begin
      set_ack    <= 1'b0;
      time_valid <= 1'b0;

      // Capture is independent of state; a pending set blocks recapture.
      if (set_req && !set_pend) begin
        set_val[0] <= set_sec;
        set_val[1] <= set_min;
        set_val[2] <= set_hour;
        set_val[3] <= set_date;
        set_val[4] <= set_month;
        set_val[5] <= set_day;
        set_val[6] <= set_year;
        set_pend   <= 1'b1;
      end

      // Command held until acked, dropped on the edge after the ack; the
      // next one is raised one cycle later from the (possibly new) state.
      if (rd_done || wr_done) begin
        cmd_read_r  <= 1'b0;
        cmd_write_r <= 1'b0;
      end else if (!cmd_read_r && !cmd_write_r) begin
        if (issue_rd) begin
          cmd_read_r  <= 1'b1;
          read_addr_r <= rd_addr_nxt;
        end else if (issue_wr) begin
          cmd_write_r  <= 1'b1;
          write_addr_r <= wr_addr_nxt;
          write_data_r <= wr_data_nxt;
        end
      end

      case (state)
        S_INIT_WP: if (wr_done) state <= S_INIT_RD;
        S_INIT_RD: begin
          if (rd_done) begin
            init_sec <= io.read_data;
            state    <= S_INIT_WR;
          end
        end
        S_INIT_WR: begin
          if (wr_done) begin
            init_done <= 1'b1;
            idx       <= '0;
            state     <= S_POLL_RD;
          end
        end
        S_WAIT: begin
          if (set_pend || poll_cnt == CNT_LAST) begin
            poll_cnt <= '0;
            idx      <= '0;
            state    <= set_pend ? S_SET_WR : S_POLL_RD;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        S_POLL_RD: begin
          if (rd_done) begin
            if (idx == 3'd6) begin
              // Publish all seven bytes on one edge so readers never see a mix.
              sec        <= shadow[0];
              min        <= shadow[1];
              hour       <= shadow[2];
              date       <= shadow[3];
              month      <= shadow[4];
              day        <= shadow[5];
              year       <= io.read_data;
              time_valid <= 1'b1;
              state      <= S_WAIT;
            end else begin
              shadow[idx] <= io.read_data;
              idx         <= idx + 3'd1;
            end
          end
        end
        S_SET_WR: begin
          if (wr_done) begin
            if (idx == 3'd6) begin
              set_ack  <= 1'b1;
              set_pend <= 1'b0;
              idx      <= '0;
              state    <= S_POLL_RD;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: state <= S_INIT_WP;
      endcase
    end
  end

endmodule

// File: tb/tb_ds1302_ctrl.sv
// tb_ds1302_ctrl: scoreboard bench for ds1302_ctrl with a behavioural DS1302
// I/O engine model. Expected transactions and snapshots are queued when
// stimulus is applied and compared when the DUT issues commands / pulses
// time_valid.
module tb_ds1302_ctrl;
  localparam int unsigned POLL = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_req = 1'b0;
  logic [7:0] set_sec = '0, set_min = '0, set_hour = '0, set_date = '0;
  logic [7:0] set_month = '0, set_day = '0, set_year = '0;
  logic       set_ack, time_valid, init_done, busy;
  logic [7:0] sec, min, hour, date, month, day, year;
  logic [55:0] dut_snap;

  ds1302_ctrl_if io();

  ds1302_ctrl #(.POLL_DIV(POLL)) dut (
    .clk(clk), .rst(rst),
    .set_req(set_req), .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
    .set_date(set_date), .set_month(set_month), .set_day(set_day), .set_year(set_year),
    .set_ack(set_ack),
    .sec(sec), .min(min), .hour(hour), .date(date), .month(month), .day(day), .year(year),
    .time_valid(time_valid), .init_done(init_done), .busy(busy),
    .io(io)
  );

  always #5 clk = ~clk;
  assign dut_snap = {sec, min, hour, date, month, day, year};

  int total = 0;
  int bad = 0;
  logic [16:0] tx_q[$];
  logic [55:0] snap_q[$];
  logic [7:0]  mem [0:6];
  logic [7:0]  wp_reg;
  logic [55:0] model_snap = '0;
  int lat = 2;
  int tv_cnt = 0;
  int ack_cnt = 0;
  int cyc = 0;
  int last_tv = 0;
  bit armed = 0;
  bit init_arm = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] mem_snap();
    return {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]};
  endfunction

  function automatic logic [55:0] set_snap(input logic [55:0] v);
    return {1'b0, v[54:0]};
  endfunction

  task automatic push_burst(input logic [55:0] snap);
    for (int i = 0; i < 7; i++) tx_q.push_back({1'b0, 8'h81 + 8'(2 * i), 8'h00});
    snap_q.push_back(snap);
  endtask

  task automatic push_set(input logic [55:0] v);
    logic [7:0] b;
    for (int i = 0; i < 7; i++) begin
      b = v[55 - 8 * i -: 8];
      if (i == 0) b[7] = 1'b0;
      tx_q.push_back({1'b1, 8'h80 + 8'(2 * i), b});
    end
  endtask

  task automatic push_init(input logic [7:0] cur_sec);
    tx_q.push_back({1'b1, 8'h8E, 8'h00});
    tx_q.push_back({1'b0, 8'h81, 8'h00});
    tx_q.push_back({1'b1, 8'h80, 1'b0, cur_sec[6:0]});
  endtask

  task automatic drive_set(input logic [55:0] v);
    {set_sec, set_min, set_hour, set_date, set_month, set_day, set_year} = v;
  endtask

  task automatic chk_reset();
    chk("rst_snap", 64'(dut_snap), 64'h0);
    chk("rst_flags", 64'({set_ack, time_valid, init_done, busy, io.cmd_read, io.cmd_write}), 64'h0);
    chk("rst_raddr", 64'(io.read_addr), 64'h81);
    chk("rst_waddr", 64'(io.write_addr), 64'h8E);
    chk("rst_wdata", 64'(io.write_data), 64'h00);
  endtask

  task automatic wait_tv(input int target, input int bound);
    int n = 0;
    while (tv_cnt < target && n < bound) begin @(posedge clk); n++; end
    chk("tv_wait", 64'(tv_cnt >= target), 64'd1);
  endtask

  task automatic wait_ack(input int target, input int bound);
    int n = 0;
    while (ack_cnt < target && n < bound) begin @(posedge clk); n++; end
    chk("ack_wait", 64'(ack_cnt >= target), 64'd1);
  endtask

  task automatic wait_cmd(input bit wr, input logic [7:0] addr, input int bound);
    int n = 0;
    bit hit = 0;
    while (!hit && n < bound) begin
      @(negedge clk);
      n++;
      hit = wr ? (io.cmd_write && io.write_addr == addr) : (io.cmd_read && io.read_addr == addr);
    end
    chk("cmd_wait", 64'(hit), 64'd1);
  endtask

  // Behavioural I/O engine: accepts a command when idle, acks after `lat`
  // cycles, then spends the ack-drop cycle returning to idle.
  int eng_st = 0;
  int e_cnt = 0;
  bit e_wr = 0;
  logic [7:0] e_addr, e_data;
  logic init_pre;
  initial begin
    io.cmd_read_ack = 1'b0;
    io.cmd_write_ack = 1'b0;
    io.read_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eng_st = 0;
        io.cmd_read_ack = 1'b0;
        io.cmd_write_ack = 1'b0;
      end else begin
        case (eng_st)
          0: if (io.cmd_read || io.cmd_write) begin
            chk("no_overlap", 64'(io.cmd_read & io.cmd_write), 64'd0);
            chk("busy", 64'(busy), 64'd1);
            e_wr   = io.cmd_write;
            e_addr = e_wr ? io.write_addr : io.read_addr;
            e_data = e_wr ? io.write_data : 8'h00;
            if (tx_q.size() == 0) chk("tx_unexpected", 64'(tx_q.size()), 64'd1);
            else chk("tx", 64'({e_wr, e_addr, e_data}), 64'(tx_q.pop_front()));
            e_cnt  = lat;
            eng_st = 1;
          end
          1: if (e_cnt > 1) e_cnt--;
          else begin
            chk("cmd_stable",
                64'({io.cmd_write, io.cmd_read, e_wr ? io.write_addr : io.read_addr, e_wr ? io.write_data : 8'h00}),
                64'({e_wr, ~e_wr, e_addr, e_data}));
            if (e_wr) begin
              if (e_addr <= 8'h8C) mem[(e_addr - 8'h80) >> 1] = e_data;
              else wp_reg = e_data;
              init_pre = init_done;
              io.cmd_write_ack = 1'b1;
            end else begin
              io.read_data = mem[(e_addr - 8'h81) >> 1];
              io.cmd_read_ack = 1'b1;
            end
            eng_st = 2;
          end
          default: begin
            io.cmd_read_ack = 1'b0;
            io.cmd_write_ack = 1'b0;
            if (e_wr && e_addr == 8'h80 && init_arm) begin
              chk("init_done_pre", 64'(init_pre), 64'd0);
              chk("init_done", 64'(init_done), 64'd1);
              init_arm = 0;
            end
            if (!e_wr && e_addr != 8'h8D) chk("snap_hold", 64'(dut_snap), 64'(model_snap));
            eng_st = 0;
          end
        endcase
      end
    end
  end

  logic [55:0] exp_s;
  always @(negedge clk) begin
    if (rst) begin
      armed = 0;
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      cyc++;
      if (time_valid) begin
        tv_cnt++;
        if (snap_q.size() == 0) chk("tv_unexpected", 64'(snap_q.size()), 64'd1);
        else begin
          exp_s = snap_q.pop_front();
          chk("snapshot", 64'(dut_snap), 64'(exp_s));
          model_snap = exp_s;
        end
        last_tv = cyc;
        armed = 1;
      end
      if (set_ack) ack_cnt++;
      if (io.cmd_read && !prev_rd && armed) begin
        chk("poll_gap", 64'(cyc - last_tv), 64'(POLL + 1));
        armed = 0;
      end
      if (io.cmd_write && !prev_wr) armed = 0;
      prev_rd = io.cmd_read;
      prev_wr = io.cmd_write;
    end
  end

  localparam logic [55:0] SET1 = 56'hD9_30_08_01_02_04_25;
  localparam logic [55:0] SET2 = 56'h12_34_23_28_11_07_99;
  localparam logic [55:0] SET3 = 56'h07_11_22_13_09_05_30;

  initial begin
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} = 56'h85_45_12_15_06_03_24;
    wp_reg = 8'h80;
    repeat (3) @(negedge clk);
    chk_reset();

    // Init sequence followed by the first poll burst.
    push_init(mem[0]);
    push_burst({1'b0, mem[0][6:0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]});
    init_arm = 1;
    @(negedge clk);
    rst = 1'b0;
    wait_tv(1, 2000);
    chk("wp_cleared", 64'(wp_reg), 64'h00);

    // Regular poll with new register contents.
    mem[0] = 8'h30;
    push_burst(mem_snap());
    wait_tv(2, 1000);

    // Seconds change after it was read in this burst.
    push_burst(mem_snap());
    wait_cmd(1'b0, 8'h83, 500);
    mem[0] = 8'h31;
    wait_tv(3, 500);
    push_burst(mem_snap());
    wait_tv(4, 1000);

    // Set request while waiting between polls.
    repeat (10) @(negedge clk);
    push_set(SET1);
    push_burst(set_snap(SET1));
    drive_set(SET1);
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    wait_ack(1, 1000);
    wait_tv(5, 1000);
    chk("set_ack_count1", 64'(ack_cnt), 64'd1);

    // Held set request arriving mid-burst with a slow engine.
    lat = 450;
    push_burst(set_snap(SET1));
    push_set(SET2);
    push_burst(set_snap(SET2));
    wait_cmd(1'b0, 8'h81, 300);
    drive_set(SET2);
    set_req = 1'b1;
    repeat (3000) @(negedge clk);
    set_req = 1'b0;
    wait_ack(2, 8000);
    wait_tv(7, 4000);
    lat = 2;
    push_burst(mem_snap());
    wait_tv(8, 1000);
    chk("set_ack_count2", 64'(ack_cnt), 64'd2);

    // Reset while a set write is outstanding.
    lat = 20;
    tx_q.push_back({1'b1, 8'h80, 8'h07});
    tx_q.push_back({1'b1, 8'h82, 8'h11});
    drive_set(SET3);
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    wait_cmd(1'b1, 8'h82, 500);
    rst = 1'b1;
    #1;
    chk_reset();
    tx_q.delete();
    model_snap = '0;
    repeat (3) @(negedge clk);
    lat = 2;
    push_init(mem[0]);
    push_burst({1'b0, mem[0][6:0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]});
    init_arm = 1;
    rst = 1'b0;
    wait_tv(9, 2000);
    push_burst(mem_snap());
    wait_tv(10, 1000);
    chk("set_ack_count3", 64'(ack_cnt), 64'd2);
    chk("tv_count", 64'(tv_cnt), 64'd10);
    chk("tx_drained", 64'(tx_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
